pipe_hazard_ctrl: RTL and testbench

Central hazard controller for the 5-stage pipelined core. It generates the forwarding selects for the EX-stage operand muxes, detects load-use hazards, and sequences stall/bubble/flush for taken branches and multi-cycle EX operations (divider). It sits beside the pipeline registers and drives their enable and clear inputs, plus the PC enable.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// encodings, controller FSM states and the register-index width.
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_t;

    typedef enum logic {
        ST_RUN,
        ST_MC_WAIT
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX-stage source operand; the youngest in-flight
// writer (EX/MEM) wins over MEM/WB, and x0 is never forwarded.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             ex_mem_regwrite,
    input  logic [REG_W-1:0] mem_wb_rd,
    input  logic             mem_wb_regwrite,
    output logic [1:0]       sel
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        sel = FWD_RF;
        if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == ex_rs))
            sel = FWD_EXMEM;
        else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == ex_rs))
            sel = FWD_MEMWB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: operand forwarding, load-use stall, taken-branch
// flush and multi-cycle EX stall with a watchdog, plus a stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MC_MAX = 64,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_ex_rs1,
    input  logic [REG_W-1:0] id_ex_rs2,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_regwrite,
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic [REG_W-1:0] mem_wb_rd,
    input  logic             ex_mem_regwrite,
    input  logic             mem_wb_regwrite,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    input  logic             mc_done,
    output logic [1:0]       rs1_forward,
    output logic [1:0]       rs2_forward,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             if_id_flush,
    output logic             mc_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WD_W = (MC_MAX > 2) ? $clog2(MC_MAX) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_MAX - 1);

    hz_state_t       state, state_nxt;
    logic [WD_W-1:0] mc_cnt, mc_cnt_nxt;
    logic            wd_expire;
    logic            load_use;

    fwd_sel u_fwd_rs1 (
        .ex_rs           (id_ex_rs1),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .sel             (rs1_forward)
    );

    fwd_sel u_fwd_rs2 (
        .ex_rs           (id_ex_rs2),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_regwrite (ex_mem_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .sel             (rs2_forward)
    );

    assign load_use = id_ex_memread && id_ex_regwrite && (id_ex_rd != '0) &&
                      (((id_ex_rd == id_rs1) && id_uses_rs1) ||
                       ((id_ex_rd == id_rs2) && id_uses_rs2));

    always_comb begin
        state_nxt     = state;
        mc_cnt_nxt    = mc_cnt;
        wd_expire     = 1'b0;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        if_id_flush   = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (ex_mc_start) begin
                    state_nxt = ST_MC_WAIT;
                end else if (ex_branch_taken) begin
                    // The ID instruction is killed, so a load-use match there is moot.
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_bubble = 1'b1;
                mc_cnt_nxt    = mc_cnt + 1'b1;
                if (mc_done || (mc_cnt == WD_LAST)) begin
                    wd_expire  = !mc_done;
                    state_nxt  = ST_RUN;
                    mc_cnt_nxt = '0;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state        <= ST_RUN;
            mc_cnt       <= '0;
            mc_error     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
            if (wd_expire)
                mc_error <= 1'b1;
            if (pc_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, compared cycle by cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MC_MAX = 8;
    localparam int CNT_W  = 6;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic             clk, rst_n;
    logic [4:0]       id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic             id_uses_rs1, id_uses_rs2, id_ex_regwrite, id_ex_memread;
    logic             ex_mem_regwrite, mem_wb_regwrite, ex_branch_taken, ex_mc_start, mc_done;
    logic [1:0]       rs1_forward, rs2_forward;
    logic             pc_stall, if_id_stall, id_ex_stall, id_ex_bubble, ex_mem_bubble, if_id_flush;
    logic             mc_error;
    logic [CNT_W-1:0] stall_cycles;

    pipe_hazard_ctrl #(.MC_MAX(MC_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
        .rs1_forward(rs1_forward), .rs2_forward(rs2_forward),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble), .if_id_flush(if_id_flush),
        .mc_error(mc_error), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: "busy" while a multi-cycle op is outstanding,
    // "waited" is how many stall cycles it has consumed so far.
    bit m_busy;
    int m_waited;
    bit m_err;
    int m_stalls;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == rs) return 2'd1;
        if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_err = 0; m_stalls = 0;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_ex_rs1 = 0; id_ex_rs2 = 0; id_ex_rd = 0; id_ex_regwrite = 0; id_ex_memread = 0;
        ex_mem_rd = 0; mem_wb_rd = 0; ex_mem_regwrite = 0; mem_wb_regwrite = 0;
        ex_branch_taken = 0; ex_mc_start = 0; mc_done = 0;
    endtask

    // Entered at a negedge with inputs driven; checks mid-low-phase, advances
    // the model across the next posedge, and returns at the following negedge.
    task automatic cycle(input string tag);
        bit lu;
        bit e_pc = 0, e_ifid = 0, e_idex = 0, e_bub = 0, e_exmb = 0, e_flush = 0;
        #1;
        lu = id_ex_memread && id_ex_regwrite && id_ex_rd != 0 &&
             ((id_ex_rd == id_rs1 && id_uses_rs1) || (id_ex_rd == id_rs2 && id_uses_rs2));
        if (m_busy) begin
            e_pc = 1; e_ifid = 1; e_idex = 1; e_exmb = 1;
        end else if (!ex_mc_start) begin
            if (ex_branch_taken) begin
                e_flush = 1; e_bub = 1;
            end else if (lu) begin
                e_pc = 1; e_ifid = 1; e_bub = 1;
            end
        end
        check({tag, ".rs1_forward"}, 32'(rs1_forward), 32'(ref_fwd(id_ex_rs1)));
        check({tag, ".rs2_forward"}, 32'(rs2_forward), 32'(ref_fwd(id_ex_rs2)));
        check({tag, ".pc_stall"}, 32'(pc_stall), 32'(e_pc));
        check({tag, ".if_id_stall"}, 32'(if_id_stall), 32'(e_ifid));
        check({tag, ".id_ex_stall"}, 32'(id_ex_stall), 32'(e_idex));
        check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
        check({tag, ".ex_mem_bubble"}, 32'(ex_mem_bubble), 32'(e_exmb));
        check({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(e_flush));
        check({tag, ".mc_error"}, 32'(mc_error), 32'(m_err));
        check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stalls));
        if (e_pc && m_stalls < SAT) m_stalls++;
        if (m_busy) begin
            m_waited++;
            if (mc_done) begin
                m_busy = 0;
            end else if (m_waited == MC_MAX) begin
                m_busy = 0;
                m_err  = 1;
            end
        end else if (ex_mc_start) begin
            m_busy   = 1;
            m_waited = 0;
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pc_stall"}, 32'(pc_stall), 0);
        check({tag, ".if_id_stall"}, 32'(if_id_stall), 0);
        check({tag, ".id_ex_stall"}, 32'(id_ex_stall), 0);
        check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 0);
        check({tag, ".ex_mem_bubble"}, 32'(ex_mem_bubble), 0);
        check({tag, ".if_id_flush"}, 32'(if_id_flush), 0);
        check({tag, ".mc_error"}, 32'(mc_error), 0);
        check({tag, ".stall_cycles"}, 32'(stall_cycles), 0);
    endtask

    task automatic watchdog_run(input string tag);
        ex_mc_start = 1;
        cycle({tag, ".start"});
        idle();
        repeat (MC_MAX) cycle({tag, ".wait"});
    endtask

    initial begin
        int base;
        idle();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("reset_idle");

        // Forwarding priority and the x0 exclusion.
        id_ex_rs1 = 5; ex_mem_rd = 5; mem_wb_rd = 5; ex_mem_regwrite = 1; mem_wb_regwrite = 1;
        cycle("fwd_exmem");
        check("fwd_exmem_lit", 32'(rs1_forward), 1);
        ex_mem_regwrite = 0;
        cycle("fwd_memwb");
        check("fwd_memwb_lit", 32'(rs1_forward), 2);
        ex_mem_regwrite = 1; ex_mem_rd = 0; mem_wb_rd = 0; id_ex_rs1 = 0;
        cycle("fwd_x0");
        check("fwd_x0_lit", 32'(rs1_forward), 0);

        // Load-use on rs2, then the same load with rs2 unused.
        idle();
        id_ex_memread = 1; id_ex_regwrite = 1; id_ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
        cycle("load_use");
        check("load_use_cnt", 32'(stall_cycles), 1);
        id_uses_rs2 = 0;
        cycle("load_no_use");
        check("load_no_use_stall", 32'(pc_stall), 0);

        // Taken branch overrides the load-use stall.
        id_uses_rs2 = 1; ex_branch_taken = 1;
        cycle("branch_lu");
        check("branch_lu_flush", 32'(if_id_flush), 1);
        check("branch_lu_pc", 32'(pc_stall), 0);

        // Multi-cycle op finishing 4 cycles after issue.
        idle();
        base = m_stalls;
        ex_mc_start = 1;
        cycle("mc_start");
        idle();
        repeat (3) cycle("mc_wait");
        mc_done = 1;
        cycle("mc_done");
        idle();
        check("mc_cnt", 32'(stall_cycles), 32'(base + 4));
        cycle("mc_back_run");

        // Watchdog expiry and stickiness of mc_error.
        watchdog_run("wd");
        check("wd_err", 32'(mc_error), 1);
        cycle("wd_run");
        repeat (3) cycle("wd_sticky");

        // Random traffic with small register indices to provoke matches.
        for (int i = 0; i < 300; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
            id_ex_rs1 = 5'($urandom_range(0, 3)); id_ex_rs2 = 5'($urandom_range(0, 3));
            id_ex_rd = 5'($urandom_range(0, 3));
            id_ex_regwrite = 1'($urandom); id_ex_memread = 1'($urandom);
            ex_mem_rd = 5'($urandom_range(0, 3)); mem_wb_rd = 5'($urandom_range(0, 3));
            ex_mem_regwrite = 1'($urandom); mem_wb_regwrite = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            ex_mc_start = ($urandom_range(0, 15) == 0);
            mc_done = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end
        idle();

        // Drive the stall counter into saturation.
        for (int i = 0; i < 12; i++)
            if (m_stalls < SAT) watchdog_run("sat");
        cycle("sat_run");
        check("sat_cnt", 32'(stall_cycles), SAT);

        // Asynchronous reset in the middle of a multi-cycle wait.
        ex_mc_start = 1;
        cycle("rst_mc_start");
        idle();
        repeat (2) cycle("rst_mc_wait");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid_mc");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst");
        cycle("post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
